// File: rtl/lsq_dcache_scheduler_if.sv
// Request/response bus between the LSQ scheduler and the d-cache port.
// master = scheduler, slave = cache.
interface lsq_dcache_scheduler_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  dc_req_valid;
   logic                  dc_req_write;
   logic [ADDR_WIDTH-1:0] dc_req_addr;
   logic [DATA_WIDTH-1:0] dc_req_data;
   logic                  dc_req_ready;
   logic                  dc_resp_valid;
   logic [DATA_WIDTH-1:0] dc_resp_data;

   modport master (
      output dc_req_valid, dc_req_write, dc_req_addr, dc_req_data,
      input  dc_req_ready, dc_resp_valid, dc_resp_data
   );

   modport slave (
      input  dc_req_valid, dc_req_write, dc_req_addr, dc_req_data,
      output dc_req_ready, dc_resp_valid, dc_resp_data
   );
endinterface

// File: rtl/lsq_dcache_scheduler.sv
// Arbitrates the single d-cache port between committed-store drain and the
// load-queue head, one operation in flight at a time, with load squash on flush.
//
// state      | meaning
// IDLE       | choose store or load (or nothing) this cycle
// ST_REQ     | store request presented, waiting for dc_req_ready
// ST_WAIT    | store accepted, waiting for dc_resp_valid
// LD_REQ     | load request presented, waiting for dc_req_ready
// LD_WAIT    | load accepted, waiting for dc_resp_valid
// LD_DISCARD | squashed load still in the cache; drop its response
module lsq_dcache_scheduler #(
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int ID_WIDTH         = 6,
   parameter int CNT_WIDTH        = 4,
   parameter int STORE_HIGH_WATER = 4,
   parameter int STARVE_LIMIT     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  st_commit,
   input  logic                  st_head_valid,
   input  logic [ADDR_WIDTH-1:0] st_head_addr,
   input  logic [DATA_WIDTH-1:0] st_head_data,
   output logic                  st_pop,
   input  logic                  ld_head_valid,
   input  logic [ADDR_WIDTH-1:0] ld_head_addr,
   input  logic [ID_WIDTH-1:0]   ld_head_id,
   output logic                  ld_pop,
   input  logic                  flush,
   lsq_dcache_scheduler_if.master dc,
   output logic                  ld_wb_valid,
   output logic [DATA_WIDTH-1:0] ld_wb_data,
   output logic [ID_WIDTH-1:0]   ld_wb_id,
   output logic [CNT_WIDTH-1:0]  committed_stores,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT, LD_DISCARD
   } state_t;

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] HIGH_WATER = CNT_WIDTH'(STORE_HIGH_WATER);
   localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [SW-1:0]         starve, starve_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic                  store_elig, load_elig, store_win;
   logic                  latch_st, latch_ld, cnt_inc;

   assign store_elig = (cnt != '0) && st_head_valid;
   assign load_elig  = ld_head_valid && !flush;
   assign store_win  = store_elig &&
                       ((cnt >= HIGH_WATER) || (starve >= STARVE_MAX) || !load_elig);

   always_comb begin
      state_nxt       = state;
      starve_nxt      = starve;
      latch_st        = 1'b0;
      latch_ld        = 1'b0;
      dc.dc_req_valid = 1'b0;
      dc.dc_req_write = 1'b0;
      dc.dc_req_addr  = '0;
      dc.dc_req_data  = '0;
      st_pop          = 1'b0;
      ld_pop          = 1'b0;
      ld_wb_valid     = 1'b0;
      ld_wb_data      = '0;
      ld_wb_id        = '0;
      case (state)
         IDLE: begin
            if (store_win) begin
               state_nxt  = ST_REQ;
               latch_st   = 1'b1;
               starve_nxt = '0;
            end else if (load_elig) begin
               state_nxt = LD_REQ;
               latch_ld  = 1'b1;
               if (store_elig && (starve != STARVE_MAX))
                  starve_nxt = starve + 1'b1;
            end
         end
         ST_REQ: begin
            dc.dc_req_valid = 1'b1;
            dc.dc_req_write = 1'b1;
            dc.dc_req_addr  = addr_q;
            dc.dc_req_data  = data_q;
            if (dc.dc_req_ready)
               state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (dc.dc_resp_valid) begin
               st_pop    = 1'b1;
               state_nxt = IDLE;
            end
         end
         LD_REQ: begin
            // a flushed load must never be accepted, so valid is gated here
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               dc.dc_req_valid = 1'b1;
               dc.dc_req_addr  = addr_q;
               if (dc.dc_req_ready)
                  state_nxt = LD_WAIT;
            end
         end
         LD_WAIT: begin
            if (flush) begin
               state_nxt = dc.dc_resp_valid ? IDLE : LD_DISCARD;
            end else if (dc.dc_resp_valid) begin
               ld_pop      = 1'b1;
               ld_wb_valid = 1'b1;
               ld_wb_data  = dc.dc_resp_data;
               ld_wb_id    = id_q;
               state_nxt   = IDLE;
            end
         end
         LD_DISCARD: begin
            if (dc.dc_resp_valid)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // a commit at saturation is only kept when a drain frees a slot that cycle
   assign cnt_inc = st_commit && ((cnt != CNT_MAX) || st_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         starve <= '0;
         addr_q <= '0;
         data_q <= '0;
         id_q   <= '0;
      end else begin
         state  <= state_nxt;
         starve <= starve_nxt;
         if (latch_st) begin
            addr_q <= st_head_addr;
            data_q <= st_head_data;
         end else if (latch_ld) begin
            addr_q <= ld_head_addr;
            data_q <= '0;
            id_q   <= ld_head_id;
         end
         case ({cnt_inc, st_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign committed_stores = cnt;
   assign busy             = (state != IDLE);

   commit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(st_commit && (cnt == CNT_MAX) && !st_pop));

endmodule

// File: tb/tb_lsq_dcache_scheduler.sv
// Scoreboard bench for lsq_dcache_scheduler: expected cache requests and load
// writebacks are queued as stimulus is set up and popped as the DUT produces them.
module tb_lsq_dcache_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_commit, st_head_valid, st_pop;
   logic [31:0] st_head_addr, st_head_data;
   logic        ld_head_valid, ld_pop, flush;
   logic [31:0] ld_head_addr;
   logic [5:0]  ld_head_id;
   logic        ld_wb_valid;
   logic [31:0] ld_wb_data;
   logic [5:0]  ld_wb_id;
   logic [3:0]  committed_stores;
   logic        busy;

   lsq_dcache_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dc_if ();

   lsq_dcache_scheduler #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6), .CNT_WIDTH(4),
      .STORE_HIGH_WATER(4), .STARVE_LIMIT(8)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .st_commit(st_commit), .st_head_valid(st_head_valid),
      .st_head_addr(st_head_addr), .st_head_data(st_head_data), .st_pop(st_pop),
      .ld_head_valid(ld_head_valid), .ld_head_addr(ld_head_addr),
      .ld_head_id(ld_head_id), .ld_pop(ld_pop), .flush(flush),
      .dc(dc_if),
      .ld_wb_valid(ld_wb_valid), .ld_wb_data(ld_wb_data), .ld_wb_id(ld_wb_id),
      .committed_stores(committed_stores), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic [5:0] id; logic [31:0] data; } ld_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

   ld_t         ld_list[$];
   st_t         st_list[$];
   logic [64:0] exp_req_q[$];
   logic [37:0] exp_wb_q[$];

   int          checks = 0, errors = 0;
   int          cyc = 0, accept_cyc = 0, lat_at_accept = 0;
   int          resp_lat = 2, resp_timer = 0;
   int          wb_seen = 0, accepts = 0, req_valid_cyc = 0;
   logic [31:0] resp_word = '0;
   logic        flush_pre = 1'b0, commit_on_resp = 1'b0;
   logic        saw_accept = 1'b0, saw_st_pop = 1'b0, busy_s = 1'b0;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_heads();
      st_head_valid = (st_list.size() > 0);
      st_head_addr  = st_head_valid ? st_list[0].addr : '0;
      st_head_data  = st_head_valid ? st_list[0].data : '0;
      ld_head_valid = (ld_list.size() > 0);
      ld_head_addr  = ld_head_valid ? ld_list[0].addr : '0;
      ld_head_id    = ld_head_valid ? ld_list[0].id   : '0;
   endtask

   task automatic add_load(input logic [31:0] a, input logic [5:0] id, input logic [31:0] d);
      ld_t e;
      e.addr = a; e.id = id; e.data = d;
      ld_list.push_back(e);
      exp_wb_q.push_back({d, id});
   endtask

   task automatic add_store(input logic [31:0] a, input logic [31:0] d);
      st_t e;
      e.addr = a; e.data = d;
      st_list.push_back(e);
   endtask

   task automatic expect_req(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_req_q.push_back({w, a, d});
   endtask

   // One clock: observe at the falling edge, then update stimulus just after the rising edge.
   task automatic step();
      logic [64:0] er;
      logic [37:0] ew;
      @(negedge clk);
      cyc++;
      saw_accept = 1'b0;
      saw_st_pop = 1'b0;
      if (dc_if.dc_req_valid) req_valid_cyc++;
      if (dc_if.dc_req_valid && dc_if.dc_req_ready) begin
         saw_accept = 1'b1;
         accepts++;
         if (exp_req_q.size() == 0) chk("req_unexpected", 1, 0);
         else begin
            er = exp_req_q.pop_front();
            chk("req", {dc_if.dc_req_write, dc_if.dc_req_addr, dc_if.dc_req_data}, er);
         end
         resp_timer    = resp_lat;
         lat_at_accept = resp_lat;
         accept_cyc    = cyc;
         resp_word     = (!dc_if.dc_req_write && ld_list.size() > 0) ? ld_list[0].data : 32'h0;
      end
      if (ld_pop || ld_wb_valid) begin
         chk("ld_pop_with_wb", {ld_pop, ld_wb_valid}, 2'b11);
         if (exp_wb_q.size() == 0) chk("wb_unexpected", 1, 0);
         else begin
            ew = exp_wb_q.pop_front();
            chk("wb", {ld_wb_data, ld_wb_id}, ew);
         end
         chk("wb_latency", cyc - accept_cyc, lat_at_accept);
         wb_seen++;
         if (ld_list.size() > 0) void'(ld_list.pop_front());
      end
      if (st_pop) begin
         saw_st_pop = 1'b1;
         if (st_list.size() > 0) void'(st_list.pop_front());
      end
      busy_s = busy;
      @(posedge clk);
      #1;
      st_commit = 1'b0;
      flush     = 1'b0;
      if (resp_timer > 0) begin
         resp_timer--;
         if (flush_pre && resp_timer == 1) begin
            flush     = 1'b1;
            flush_pre = 1'b0;
         end
         dc_if.dc_resp_valid = (resp_timer == 0);
         if (resp_timer == 0 && commit_on_resp) begin
            st_commit      = 1'b1;
            commit_on_resp = 1'b0;
         end
      end else begin
         dc_if.dc_resp_valid = 1'b0;
      end
      dc_if.dc_resp_data = dc_if.dc_resp_valid ? resp_word : 32'h0;
      drive_heads();
   endtask

   task automatic wait_idle(input string tag, input int max);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (!done && n < max) begin
         step();
         n++;
         done = (exp_req_q.size() == 0) && (exp_wb_q.size() == 0) &&
                (resp_timer == 0) && !busy_s;
      end
      chk({tag, "_done"}, done, 1);
   endtask

   task automatic wait_event(input string tag, input bit want_pop, input int max);
      int n;
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < max) begin
         step();
         n++;
         hit = want_pop ? saw_st_pop : saw_accept;
      end
      chk(tag, hit, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int w0, r0;
      rst_n = 1'b0;
      st_commit = 1'b0;
      flush = 1'b0;
      dc_if.dc_req_ready  = 1'b1;
      dc_if.dc_resp_valid = 1'b0;
      dc_if.dc_resp_data  = '0;
      drive_heads();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset state
      chk("rst_req_valid", dc_if.dc_req_valid, 0);
      chk("rst_req_write", dc_if.dc_req_write, 0);
      chk("rst_req_addr",  dc_if.dc_req_addr, 0);
      chk("rst_req_data",  dc_if.dc_req_data, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_count",     committed_stores, 0);
      chk("rst_pops",      {st_pop, ld_pop}, 0);
      chk("rst_wb",        {ld_wb_valid, ld_wb_data, ld_wb_id}, 0);

      // single load, response two cycles after accept
      resp_lat = 2;
      r0 = req_valid_cyc;
      add_load(32'h100, 6'd5, 32'hDEADBEEF);
      expect_req(1'b0, 32'h100, 32'h0);
      drive_heads();
      wait_idle("single_load", 30);
      chk("single_load_req_cycles", req_valid_cyc - r0, 1);

      // reset while a load is outstanding; its late response must be ignored
      st_commit = 1'b1; step();
      st_commit = 1'b1; step();
      chk("count_after_2_commits", committed_stores, 2);
      resp_lat = 4;
      add_load(32'h300, 6'd7, 32'h1234);
      expect_req(1'b0, 32'h300, 32'h0);
      drive_heads();
      wait_event("midop_accept", 1'b0, 10);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      ld_list.delete();
      exp_wb_q.delete();
      drive_heads();
      chk("midop_busy", busy, 0);
      chk("midop_req_valid", dc_if.dc_req_valid, 0);
      chk("midop_count", committed_stores, 0);
      w0 = wb_seen;
      repeat (5) step();
      chk("midop_late_resp_ignored", wb_seen - w0, 0);
      chk("midop_still_idle", busy, 0);

      // high-water: four committed stores beat a pending load
      resp_lat = 2;
      repeat (4) begin st_commit = 1'b1; step(); end
      chk("hw_count", committed_stores, 4);
      add_store(32'h200, 32'h55);
      add_store(32'h204, 32'h66);
      add_store(32'h208, 32'h77);
      add_store(32'h20C, 32'h88);
      add_load(32'h400, 6'd9, 32'hCAFE0001);
      expect_req(1'b1, 32'h200, 32'h55);
      expect_req(1'b0, 32'h400, 32'h0);
      expect_req(1'b1, 32'h204, 32'h66);
      expect_req(1'b1, 32'h208, 32'h77);
      expect_req(1'b1, 32'h20C, 32'h88);
      drive_heads();
      wait_event("hw_first_pop", 1'b1, 20);
      chk("hw_count_after_pop", committed_stores, 3);
      wait_idle("high_water", 80);
      chk("hw_count_drained", committed_stores, 0);

      // starvation: eight load wins then the store; a second round shows the counter cleared
      resp_lat = 1;
      for (int ph = 0; ph < 2; ph++) begin
         int nl;
         nl = (ph == 0) ? 10 : 9;
         for (int i = 0; i < nl; i++) begin
            add_load(32'h1000 + 32'(ph * 64 + i * 4), 6'(10 + i), 32'hA000_0000 + 32'(ph * 16 + i));
            if (i == 8) expect_req(1'b1, 32'h500 + 32'(ph), 32'hBB + 32'(ph));
            expect_req(1'b0, 32'h1000 + 32'(ph * 64 + i * 4), 32'h0);
         end
         add_store(32'h500 + 32'(ph), 32'hBB + 32'(ph));
         drive_heads();
         st_commit = 1'b1;
         flush     = 1'b1;
         step();
         wait_idle(ph == 0 ? "starve_round0" : "starve_round1", 200);
         chk("starve_count_drained", committed_stores, 0);
      end

      // flush in LD_WAIT one cycle ahead of the response
      resp_lat  = 3;
      flush_pre = 1'b1;
      w0 = wb_seen;
      r0 = accepts;
      add_load(32'h600, 6'd21, 32'h600D600D);
      expect_req(1'b0, 32'h600, 32'h0);
      expect_req(1'b0, 32'h600, 32'h0);
      drive_heads();
      wait_idle("flush_wait", 60);
      chk("flush_wait_wb_once", wb_seen - w0, 1);
      chk("flush_wait_reissued", accepts - r0, 2);

      // flush in LD_REQ under backpressure: request withdrawn, never accepted
      resp_lat = 1;
      dc_if.dc_req_ready = 1'b0;
      add_load(32'h700, 6'd22, 32'h77);
      drive_heads();
      step();
      chk("ldreq_valid", {dc_if.dc_req_valid, dc_if.dc_req_write, dc_if.dc_req_addr}, {2'b10, 32'h700});
      flush = 1'b1;
      #1;
      chk("ldreq_flush_gates_valid", dc_if.dc_req_valid, 0);
      step();
      chk("ldreq_flush_idle", busy, 0);
      dc_if.dc_req_ready = 1'b1;
      expect_req(1'b0, 32'h700, 32'h0);
      wait_idle("ldreq_retry", 30);

      // store backpressure, then a commit in the same cycle as st_pop
      dc_if.dc_req_ready = 1'b0;
      add_store(32'h800, 32'h1111);
      add_store(32'h804, 32'h2222);
      expect_req(1'b1, 32'h800, 32'h1111);
      expect_req(1'b1, 32'h804, 32'h2222);
      drive_heads();
      st_commit = 1'b1;
      step();
      for (int i = 0; i < 10 && !dc_if.dc_req_valid; i++) step();
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold", {dc_if.dc_req_valid, dc_if.dc_req_write, dc_if.dc_req_addr, dc_if.dc_req_data},
             {2'b11, 32'h800, 32'h1111});
         step();
      end
      commit_on_resp = 1'b1;
      dc_if.dc_req_ready = 1'b1;
      wait_event("bp_pop", 1'b1, 20);
      chk("bp_count_unchanged", committed_stores, 1);
      wait_idle("bp_drain", 40);
      chk("bp_count_drained", committed_stores, 0);

      chk("final_req_queue_empty", exp_req_q.size(), 0);
      chk("final_wb_queue_empty", exp_wb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
